// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: a WIDTH-bit add/subtract split into STAGES ripple chunks,
// one register boundary per chunk, with valid/ready handshake and a global stall.
module pipelined_addsub #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out,
  output logic             ovf_out,
  output logic             zero_out
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int MSB   = WIDTH - 1;

  // Slot k holds the state after stage k; the last slot is the output register.
  logic [WIDTH-1:0] pa [STAGES];
  logic [WIDTH-1:0] pb [STAGES];
  logic [WIDTH-1:0] ps [STAGES];
  logic             pc [STAGES];
  logic             pv [STAGES];
  logic             ovf_q;
  logic             zero_q;

  logic [WIDTH-1:0] nxt_s [STAGES];
  logic             nxt_c [STAGES];
  logic [WIDTH-1:0] b_prep;
  logic             c_prep;
  logic [WIDTH-1:0] last_a;
  logic [WIDTH-1:0] last_b;
  logic [WIDTH:0]   step;
  logic             ovf_nxt;
  logic             stall;

  // Adds chunk k of a and b plus carry c, inserting the result into partial sum s.
  function automatic logic [WIDTH:0] stage_step(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] s,
    input logic             c,
    input int               k
  );
    logic [CHUNK:0]   part;
    logic [WIDTH-1:0] r;
    part = {1'b0, a[k*CHUNK +: CHUNK]} + {1'b0, b[k*CHUNK +: CHUNK]}
         + {{CHUNK{1'b0}}, c};
    r = s;
    r[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
    return {part[CHUNK], r};
  endfunction

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  always_comb begin
    b_prep   = in_sub ? ~in_b : in_b;
    c_prep   = in_sub | in_c;
    step     = stage_step(in_a, b_prep, {WIDTH{1'b0}}, c_prep, 0);
    nxt_c[0] = step[WIDTH];
    nxt_s[0] = step[WIDTH-1:0];
    last_a   = in_a;
    last_b   = b_prep;
    for (int k = 1; k < STAGES; k++) begin
      step     = stage_step(pa[k-1], pb[k-1], ps[k-1], pc[k-1], k);
      nxt_c[k] = step[WIDTH];
      nxt_s[k] = step[WIDTH-1:0];
      last_a   = pa[k-1];
      last_b   = pb[k-1];
    end
    ovf_nxt = (last_a[MSB] == last_b[MSB]) && (nxt_s[STAGES-1][MSB] != last_a[MSB]);
  end

  // The whole pipe, valid bits included, advances together or holds together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        pa[k] <= '0;
        pb[k] <= '0;
        ps[k] <= '0;
        pc[k] <= 1'b0;
        pv[k] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (!stall) begin
      pa[0] <= in_a;
      pb[0] <= b_prep;
      ps[0] <= nxt_s[0];
      pc[0] <= nxt_c[0];
      pv[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        pa[k] <= pa[k-1];
        pb[k] <= pb[k-1];
        ps[k] <= nxt_s[k];
        pc[k] <= nxt_c[k];
        pv[k] <= pv[k-1];
      end
      ovf_q  <= ovf_nxt;
      zero_q <= ~|nxt_s[STAGES-1];
    end
  end

  assign out_valid = pv[STAGES-1];
  assign sum_out   = ps[STAGES-1];
  assign c_out     = pc[STAGES-1];
  assign ovf_out   = ovf_q;
  assign zero_out  = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: 8/2 main instance plus 16/4 and 8/1 variants.
module tb_pipelined_addsub;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  logic       in_valid, in_ready, in_c, in_sub, out_valid, out_ready;
  logic [7:0] in_a, in_b, sum_out;
  logic       c_out, ovf_out, zero_out;

  logic        w_in_valid, w_in_ready, w_in_c, w_in_sub, w_out_valid, w_out_ready;
  logic [15:0] w_in_a, w_in_b, w_sum_out;
  logic        w_c_out, w_ovf_out, w_zero_out;

  logic       s_in_valid, s_in_ready, s_in_c, s_in_sub, s_out_valid, s_out_ready;
  logic [7:0] s_in_a, s_in_b, s_sum_out;
  logic       s_c_out, s_ovf_out, s_zero_out;

  pipelined_addsub #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out),
    .c_out(c_out), .ovf_out(ovf_out), .zero_out(zero_out)
  );

  pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut_wide (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_a(w_in_a), .in_b(w_in_b), .in_c(w_in_c), .in_sub(w_in_sub),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .sum_out(w_sum_out),
    .c_out(w_c_out), .ovf_out(w_ovf_out), .zero_out(w_zero_out)
  );

  pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut_single (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_c(s_in_c), .in_sub(s_in_sub),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .sum_out(s_sum_out),
    .c_out(s_c_out), .ovf_out(s_ovf_out), .zero_out(s_zero_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation into the 8/2 instance and returns at the negedge where it is presented.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sub);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_c = c; in_sub = sub;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic w_issue(input logic [15:0] a, input logic [15:0] b, input logic c, input logic sub);
    @(negedge clk);
    w_in_valid = 1'b1; w_in_a = a; w_in_b = b; w_in_c = c; w_in_sub = sub;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic s_issue(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sub);
    @(negedge clk);
    s_in_valid = 1'b1; s_in_a = a; s_in_b = b; s_in_c = c; s_in_sub = sub;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    compared++; if (sum_out !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_sum: got %h expected 00", sum_out); end
    compared++; if ({c_out, ovf_out, zero_out} !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_flags: got %b expected 000", {c_out, ovf_out, zero_out}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_add_wrap;
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h01; in_c = 1'b0; in_sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL wrap_early_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_valid: got %b expected 1", out_valid); end
    compared++; if (sum_out !== 8'h00) begin mismatched++; $display("[TB] FAIL wrap_sum: got %h expected 00", sum_out); end
    compared++; if ({c_out, ovf_out, zero_out} !== 3'b101) begin mismatched++; $display("[TB] FAIL wrap_flags: got %b expected 101", {c_out, ovf_out, zero_out}); end
  endtask

  task automatic test_carry_chunks;
    issue(8'h0F, 8'h00, 1'b1, 1'b0);
    compared++; if (sum_out !== 8'h10) begin mismatched++; $display("[TB] FAIL chunk_carry_sum: got %h expected 10", sum_out); end
    compared++; if ({c_out, ovf_out, zero_out} !== 3'b000) begin mismatched++; $display("[TB] FAIL chunk_carry_flags: got %b expected 000", {c_out, ovf_out, zero_out}); end
    issue(8'h7F, 8'h01, 1'b0, 1'b0);
    compared++; if (sum_out !== 8'h80) begin mismatched++; $display("[TB] FAIL ovf_sum: got %h expected 80", sum_out); end
    compared++; if ({c_out, ovf_out, zero_out} !== 3'b010) begin mismatched++; $display("[TB] FAIL ovf_flags: got %b expected 010", {c_out, ovf_out, zero_out}); end
  endtask

  task automatic test_subtract;
    issue(8'h80, 8'h01, 1'b0, 1'b1);
    compared++; if (sum_out !== 8'h7F) begin mismatched++; $display("[TB] FAIL sub_ovf_sum: got %h expected 7f", sum_out); end
    compared++; if ({c_out, ovf_out, zero_out} !== 3'b110) begin mismatched++; $display("[TB] FAIL sub_ovf_flags: got %b expected 110", {c_out, ovf_out, zero_out}); end
    issue(8'h03, 8'h05, 1'b1, 1'b1);
    compared++; if (sum_out !== 8'hFE) begin mismatched++; $display("[TB] FAIL sub_borrow_sum: got %h expected fe", sum_out); end
    compared++; if ({c_out, ovf_out, zero_out} !== 3'b000) begin mismatched++; $display("[TB] FAIL sub_borrow_flags: got %b expected 000", {c_out, ovf_out, zero_out}); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ta [6];
    logic [7:0] tb [6];
    logic       ts [6];
    logic [7:0] te [6];
    ta = '{8'h01, 8'h10, 8'hFF, 8'h50, 8'h00, 8'h7F};
    tb = '{8'h02, 8'h20, 8'hFF, 8'h30, 8'h00, 8'h7F};
    ts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    te = '{8'h03, 8'h30, 8'hFE, 8'h20, 8'h00, 8'hFE};
    for (int cyc = 0; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (cyc == 1 || cyc == 8) begin
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_idle_valid[%0d]: got %b expected 0", cyc, out_valid); end
      end else if (cyc >= 2) begin
        compared++; if (out_valid !== 1'b1 || sum_out !== te[cyc-2]) begin mismatched++; $display("[TB] FAIL b2b_result[%0d]: got valid %b sum %h expected valid 1 sum %h", cyc-2, out_valid, sum_out, te[cyc-2]); end
      end
      if (cyc < 6) begin
        in_valid = 1'b1; in_a = ta[cyc]; in_b = tb[cyc]; in_c = 1'b0; in_sub = ts[cyc];
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_stall;
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'h11; in_b = 8'h01; in_c = 1'b0; in_sub = 1'b0;
    @(negedge clk);
    in_a = 8'h22;
    @(negedge clk);
    out_ready = 1'b0;
    in_a = 8'h33;
    #1;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_in_ready_enter: got %b expected 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready); end
      compared++; if (out_valid !== 1'b1 || sum_out !== 8'h12 || {c_out, ovf_out, zero_out} !== 3'b000) begin mismatched++; $display("[TB] FAIL stall_hold[%0d]: got valid %b sum %h flags %b expected valid 1 sum 12 flags 000", i, out_valid, sum_out, {c_out, ovf_out, zero_out}); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    compared++; if (out_valid !== 1'b1 || sum_out !== 8'h23) begin mismatched++; $display("[TB] FAIL stall_drain0: got valid %b sum %h expected valid 1 sum 23", out_valid, sum_out); end
    @(negedge clk);
    compared++; if (out_valid !== 1'b1 || sum_out !== 8'h34) begin mismatched++; $display("[TB] FAIL stall_drain1: got valid %b sum %h expected valid 1 sum 34", out_valid, sum_out); end
    @(negedge clk);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_drain_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_midflight;
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'h05; in_b = 8'h06; in_c = 1'b0; in_sub = 1'b0;
    @(negedge clk);
    in_a = 8'h07; in_b = 8'h08;
    @(posedge clk); #2;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_valid: got %b expected 0", out_valid); end
    compared++; if (sum_out !== 8'h00 || {c_out, ovf_out, zero_out} !== 3'b000) begin mismatched++; $display("[TB] FAIL midreset_outputs: got sum %h flags %b expected sum 00 flags 000", sum_out, {c_out, ovf_out, zero_out}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_no_stale: got %b expected 0", out_valid); end
    in_valid = 1'b1; in_a = 8'h01; in_b = 8'h01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_early_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    compared++; if (out_valid !== 1'b1 || sum_out !== 8'h02) begin mismatched++; $display("[TB] FAIL midreset_fresh: got valid %b sum %h expected valid 1 sum 02", out_valid, sum_out); end
  endtask

  task automatic test_wide;
    @(negedge clk);
    w_in_valid = 1'b1; w_in_a = 16'hFFFF; w_in_b = 16'h0001; w_in_c = 1'b0; w_in_sub = 1'b0;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++; if (w_out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL wide_early_valid[%0d]: got %b expected 0", i, w_out_valid); end
    end
    @(negedge clk);
    compared++; if (w_out_valid !== 1'b1 || w_sum_out !== 16'h0000) begin mismatched++; $display("[TB] FAIL wide_wrap: got valid %b sum %h expected valid 1 sum 0000", w_out_valid, w_sum_out); end
    compared++; if ({w_c_out, w_ovf_out, w_zero_out} !== 3'b101) begin mismatched++; $display("[TB] FAIL wide_wrap_flags: got %b expected 101", {w_c_out, w_ovf_out, w_zero_out}); end
    w_issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
    compared++; if (w_sum_out !== 16'h0100 || w_c_out !== 1'b0) begin mismatched++; $display("[TB] FAIL wide_chunk_carry: got sum %h c %b expected sum 0100 c 0", w_sum_out, w_c_out); end
    w_issue(16'h8000, 16'h0001, 1'b1, 1'b1);
    compared++; if (w_sum_out !== 16'h7FFF || {w_c_out, w_ovf_out, w_zero_out} !== 3'b110) begin mismatched++; $display("[TB] FAIL wide_sub: got sum %h flags %b expected sum 7fff flags 110", w_sum_out, {w_c_out, w_ovf_out, w_zero_out}); end
  endtask

  task automatic test_single;
    s_issue(8'hFF, 8'h01, 1'b0, 1'b0);
    compared++; if (s_out_valid !== 1'b1 || s_sum_out !== 8'h00) begin mismatched++; $display("[TB] FAIL single_wrap: got valid %b sum %h expected valid 1 sum 00", s_out_valid, s_sum_out); end
    compared++; if ({s_c_out, s_ovf_out, s_zero_out} !== 3'b101) begin mismatched++; $display("[TB] FAIL single_wrap_flags: got %b expected 101", {s_c_out, s_ovf_out, s_zero_out}); end
    s_issue(8'h7F, 8'h01, 1'b0, 1'b0);
    compared++; if (s_sum_out !== 8'h80 || {s_c_out, s_ovf_out, s_zero_out} !== 3'b010) begin mismatched++; $display("[TB] FAIL single_ovf: got sum %h flags %b expected sum 80 flags 010", s_sum_out, {s_c_out, s_ovf_out, s_zero_out}); end
    s_issue(8'h03, 8'h05, 1'b1, 1'b1);
    compared++; if (s_sum_out !== 8'hFE || {s_c_out, s_ovf_out, s_zero_out} !== 3'b000) begin mismatched++; $display("[TB] FAIL single_sub: got sum %h flags %b expected sum fe flags 000", s_sum_out, {s_c_out, s_ovf_out, s_zero_out}); end
    @(negedge clk);
    compared++; if (s_out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_drained: got %b expected 0", s_out_valid); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish within its time budget");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_c = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_in_c = 1'b0; w_in_sub = 1'b0; w_out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_c = 1'b0; s_in_sub = 1'b0; s_out_ready = 1'b1;
    test_reset;
    test_add_wrap;
    test_carry_chunks;
    test_subtract;
    test_back_to_back;
    test_stall;
    test_reset_midflight;
    test_wide;
    test_single;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
